i2s_transmitter: RTL and testbench

- Downstream neighbour of i2s_receiver in the akm4117 I2S chain.
- Takes the parallel stereo pair (data_left/data_right) plus the receiver's per-frame `stop` strobe, buffers one pair, and re-serialises it as standard I2S onto `sdti` toward the DAC/codec.
- Slave to the externally supplied `bick`/`lrck`; it never generates clocks.

---
 rtl/i2s_transmitter_pkg.sv | 14 +
 rtl/i2s_transmitter_lrck_edge_detect.sv | 21 ++
 rtl/i2s_transmitter.sv | 113 +++++++++++
 tb/tb_i2s_transmitter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_transmitter_pkg.sv
// Shared I2S chain definitions: width defaults and the IDLE/LEFT/RIGHT state encoding
// used by both i2s_receiver and i2s_transmitter.
package i2s_transmitter_pkg;

    localparam int DATA_W_DEF = 24;
    localparam int SLOT_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_e;

endpackage

// File: rtl/i2s_transmitter_lrck_edge_detect.sv
// Word-select edge detector: registers lrck and flags the cycle in which it differs
// from its previous value (fall = left start, rise = right start).
module lrck_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic lrck_i,
    output logic fall_o,
    output logic rise_o
);

    logic lrck_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) lrck_q <= 1'b0;
        else         lrck_q <= lrck_i;
    end

    assign fall_o = lrck_q & ~lrck_i;
    assign rise_o = ~lrck_q & lrck_i;

endmodule

// File: rtl/i2s_transmitter.sv
// I2S slave transmitter: buffers one stereo pair and shifts it out MSB-first with the
// I2S one-bit delay. Build option I2S_TX_MUTE_ON_UNDERRUN_EN outputs silence on underrun.
module i2s_transmitter
    import i2s_transmitter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SLOT_W = SLOT_W_DEF
) (
    input  logic              bick,
    input  logic              reset,
    input  logic              lrck,
    input  logic              load,
    input  logic [DATA_W-1:0] data_left,
    input  logic [DATA_W-1:0] data_right,
    output logic              sdti,
    output logic              frame_start,
    output logic              underrun,
    output logic              overrun
);

    localparam int CNT_W = $clog2(SLOT_W + 1);

    logic              fall, rise;
    state_e            state_q;
    logic [DATA_W-1:0] pend_l_q, pend_r_q, sh_l_q, sh_r_q, shift_q;
    logic              pend_valid_q;
    logic [CNT_W-1:0]  cnt_q, cnt_inc;
    logic              sdti_q, frame_start_q, underrun_q, overrun_q;
    logic [DATA_W-1:0] nxt_l, nxt_r;

    lrck_edge_detect u_edge (
        .clk_i  (bick),
        .rst_ni (reset),
        .lrck_i (lrck),
        .fall_o (fall),
        .rise_o (rise)
    );

    // Pair that is live after this cycle's left-start transfer (or underrun policy)
    always_comb begin
        nxt_l = sh_l_q;
        nxt_r = sh_r_q;
        if (fall) begin
            if (pend_valid_q) begin
                nxt_l = pend_l_q;
                nxt_r = pend_r_q;
            end
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
            else begin
                nxt_l = '0;
                nxt_r = '0;
            end
`endif
        end
    end

    assign cnt_inc = (cnt_q == CNT_W'(SLOT_W)) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge bick or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            pend_l_q      <= '0;
            pend_r_q      <= '0;
            pend_valid_q  <= 1'b0;
            sh_l_q        <= '0;
            sh_r_q        <= '0;
            shift_q       <= '0;
            cnt_q         <= '0;
            sdti_q        <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            frame_start_q <= fall;
            underrun_q    <= fall & ~pend_valid_q;
            // A load coinciding with a transfer is not an overrun: the old pair was consumed
            overrun_q     <= load & pend_valid_q & ~fall;

            if (fall) pend_valid_q <= 1'b0;
            if (load) begin
                pend_l_q     <= data_left;
                pend_r_q     <= data_right;
                pend_valid_q <= 1'b1;
            end

            sh_l_q <= nxt_l;
            sh_r_q <= nxt_r;
            cnt_q  <= (fall | rise) ? '0 : cnt_inc;

            if (fall) begin
                state_q <= ST_LEFT;
                sdti_q  <= nxt_l[DATA_W-1];
                shift_q <= {nxt_l[DATA_W-2:0], 1'b0};
            end else if (rise && state_q != ST_IDLE) begin
                state_q <= ST_RIGHT;
                sdti_q  <= sh_r_q[DATA_W-1];
                shift_q <= {sh_r_q[DATA_W-2:0], 1'b0};
            end else if (state_q == ST_IDLE) begin
                sdti_q <= 1'b0;
            end else begin
                // cnt_q is the index of the bit now on sdti; past the word, hold zero
                sdti_q  <= (cnt_q < CNT_W'(DATA_W - 1)) & shift_q[DATA_W-1];
                shift_q <= {shift_q[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign sdti        = sdti_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Scoreboarded bench for i2s_transmitter: the driver models the pending buffer and
// pushes one expected frame per lrck falling edge; the monitor checks each frame.
module tb_i2s_transmitter;

    logic        bick = 1'b0, reset = 1'b0, lrck = 1'b1, load = 1'b0;
    logic [23:0] data_left = '0, data_right = '0;
    logic        sdti, frame_start, underrun, overrun;

    int total = 0, bad = 0;

    i2s_transmitter #(.DATA_W(24), .SLOT_W(32)) dut (
        .bick        (bick),
        .reset       (reset),
        .lrck        (lrck),
        .load        (load),
        .data_left   (data_left),
        .data_right  (data_right),
        .sdti        (sdti),
        .frame_start (frame_start),
        .underrun    (underrun),
        .overrun     (overrun)
    );

    always #10 bick = ~bick;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic        ur;
        int          half;
    } exp_t;
    exp_t exp_q[$];

    logic [23:0] m_pl = '0, m_pr = '0, m_sl = '0, m_sr = '0;
    logic        m_pv = 1'b0;
    int half_len = 32, next_half = 32, phase = 0;
    bit fell = 1'b0, freeze = 1'b0;
    int exp_ur = 0, exp_or = 0, exp_fs = 0;
    int seen_ur = 0, seen_or = 0, seen_fs = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic logic slot_bit(input logic [23:0] w, input int k);
        logic b;
        b = 1'b0;
        if (k < 24) b = w[23-k];
        return b;
    endfunction

    // One bick cycle of stimulus: advances lrck, drives load, updates the model
    task automatic cyc(input bit ld, input logic [23:0] l, input logic [23:0] r);
        @(posedge bick); #1;
        fell = 1'b0;
        phase++;
        if (phase >= half_len) begin
            phase = 0;
            if (lrck == 1'b1) begin
                if (!freeze) begin
                    lrck     = 1'b0;
                    fell     = 1'b1;
                    half_len = next_half;
                end
            end else begin
                lrck = 1'b1;
            end
        end
        load       = ld;
        data_left  = l;
        data_right = r;
        if (reset) begin
            if (fell) begin
                exp_fs++;
                if (m_pv) begin
                    m_sl = m_pl;
                    m_sr = m_pr;
                    m_pv = 1'b0;
                    exp_q.push_back(exp_t'{m_sl, m_sr, 1'b0, half_len});
                end else begin
                    exp_ur++;
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
                    m_sl = '0;
                    m_sr = '0;
`endif
                    exp_q.push_back(exp_t'{m_sl, m_sr, 1'b1, half_len});
                end
            end
            if (ld) begin
                if (m_pv && !fell) exp_or++;
                m_pl = l;
                m_pr = r;
                m_pv = 1'b1;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0);
    endtask

    task automatic run_to_fall();
        int guard;
        guard = 0;
        do begin
            cyc(1'b0, '0, '0);
            guard++;
        end while (!fell && guard < 200);
        check("fall_within_budget", 32'(fell), 32'd1);
    endtask

    task automatic fall_with_load(input logic [23:0] l, input logic [23:0] r);
        int guard;
        guard = 0;
        while (!(phase == half_len - 1 && lrck == 1'b1) && guard < 200) begin
            cyc(1'b0, '0, '0);
            guard++;
        end
        cyc(1'b1, l, r);
        check("coincident_fall", 32'(fell), 32'd1);
    endtask

    // Pulse counters for flags outside the frame-aligned checks
    always @(negedge bick) begin
        if (reset === 1'b1) begin
            if (underrun === 1'b1)    seen_ur++;
            if (overrun === 1'b1)     seen_or++;
            if (frame_start === 1'b1) seen_fs++;
        end
    end

    // Monitor: each frame_start pops one expected frame and captures both slots
    initial begin
        exp_t        e;
        logic [31:0] gl, gr, wl, wr;
        bit          ab;
        forever begin
            @(negedge bick);
            if (reset === 1'b1 && frame_start === 1'b1) begin
                check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("underrun_flag", 32'(underrun), 32'(e.ur));
                    gl = '0; gr = '0; wl = '0; wr = '0; ab = 1'b0;
                    for (int i = 0; i < 2 * e.half; i++) begin
                        if (i > 0) @(negedge bick);
                        if (reset !== 1'b1) begin
                            ab = 1'b1;
                            check("abort_sdti", 32'(sdti), 32'd0);
                            break;
                        end
                        if (i < e.half) begin
                            gl = {gl[30:0], sdti};
                            wl = {wl[30:0], slot_bit(e.l, i)};
                        end else begin
                            gr = {gr[30:0], sdti};
                            wr = {wr[30:0], slot_bit(e.r, i - e.half)};
                        end
                    end
                    if (!ab) begin
                        check("left_slot", gl, wl);
                        check("right_slot", gr, wr);
                    end
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge bick);
        @(negedge bick);
        check("rst_sdti", 32'(sdti), 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        @(posedge bick); #1;
        reset = 1'b1;

        // First pair loaded before the first left start
        cyc(1'b1, 24'hA5F00F, 24'h3C0001);
        run_to_fall();                    // F1
        run_to_fall();                    // F2: underrun
        run_to_fall();                    // F3: underrun
        // Double load before one frame: overrun, newest pair wins
        run(3);
        cyc(1'b1, 24'h111111, 24'h222222);
        run(2);
        cyc(1'b1, 24'h333333, 24'h444444);
        run_to_fall();                    // F4
        // Load in the falling-edge cycle with nothing pending
        fall_with_load(24'h55AA55, 24'h0F0F0F);  // F5: underrun
        run_to_fall();                    // F6: 55AA55
        // Short half-frames truncate
        run(3);
        cyc(1'b1, 24'h9ABCDE, 24'h13579B);
        next_half = 10;
        run_to_fall();                    // F7: 10-cycle halves
        next_half = 32;
        run_to_fall();                    // F8: underrun, full length
        // Reset at bit 12 of a left word drops the pending pair
        run(3);
        cyc(1'b1, 24'h777777, 24'h888888);
        run_to_fall();                    // F9
        run(3);
        cyc(1'b1, 24'hABCDEF, 24'hFEDCBA);
        run(9);
        reset = 1'b0;
        m_pv = 1'b0; m_sl = '0; m_sr = '0;
        #1;
        check("mid_reset_sdti", 32'(sdti), 32'd0);
        check("mid_reset_frame_start", 32'(frame_start), 32'd0);
        run(3);
        reset = 1'b1;
        run_to_fall();                    // F10: underrun, zeros
        run(3);
        cyc(1'b1, 24'h123456, 24'h654321);
        run_to_fall();                    // F11
        freeze = 1'b1;
        run(70);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("underrun_count", 32'(seen_ur), 32'(exp_ur));
        check("overrun_count", 32'(seen_or), 32'(exp_or));
        check("frame_start_count", 32'(seen_fs), 32'(exp_fs));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
